// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES host-side stream controller.
package aes_stream_pkg;

  localparam int unsigned BLK = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    UNLOAD
  } state_e;

  function automatic int unsigned nb(input int unsigned dw);
    return BLK / dw;
  endfunction

endpackage

// File: rtl/aes_shift_reg.sv
// 128-bit register shifting left by DW bits per step, with a parallel-load port.
module aes_shift_reg
  import aes_stream_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift_en,
  input  logic [DW-1:0]  din,
  input  logic           load_en,
  input  logic [BLK-1:0] load_val,
  output logic [BLK-1:0] q
);

  logic [BLK-1:0] q_q, q_d;

  // Parallel load takes priority over a shift issued in the same cycle.
  always_comb begin
    q_d = q_q;
    if (load_en) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = {q_q[BLK-1-DW:0], din};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Host-side DW-bit beat stream controller for the 128-bit AES core.
// Define AES_AUTO_UNLOAD_EN to shift the result out automatically after core_done.
module aes_stream_ctrl
  import aes_stream_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  din,
  input  logic           loadkey,
  input  logic           load_shift,
  input  logic           staenc,
  input  logic           stadec,
  output logic [DW-1:0]  dout,
  output logic           dout_valid,
  output logic           busy,
  output logic           err,
  output logic [127:0]   core_key,
  output logic [127:0]   core_din,
  output logic           core_mode,
  output logic           core_start,
  input  logic [127:0]   core_dout,
  input  logic           core_done
);

  localparam int unsigned NB  = nb(DW);
  localparam int unsigned KCW = $clog2(NB + 1);

  state_e         state_q, state_d;
  logic [KCW-1:0] key_cnt_q, key_cnt_d;
  logic           err_q, err_d;
  logic           core_start_q, core_start_d;
  logic           mode_q, mode_d;
  logic           key_shift, data_shift, data_load;
  logic [DW-1:0]  data_din;
  logic           key_ok, any_cmd;

`ifdef AES_AUTO_UNLOAD_EN
  localparam int unsigned UCW = (NB > 2) ? $clog2(NB) : 1;
  logic [UCW-1:0] unl_cnt_q, unl_cnt_d;
`endif

  assign key_ok  = (key_cnt_q == KCW'(NB));
  assign any_cmd = loadkey | load_shift | staenc | stadec;

  always_comb begin
    state_d      = state_q;
    key_cnt_d    = key_cnt_q;
    err_d        = 1'b0;
    core_start_d = 1'b0;
    mode_d       = mode_q;
    key_shift    = 1'b0;
    data_shift   = 1'b0;
    data_load    = 1'b0;
    data_din     = din;
`ifdef AES_AUTO_UNLOAD_EN
    unl_cnt_d    = unl_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Loads act this cycle, so a start issued alongside them sees the updated registers.
        if (loadkey) begin
          key_shift = 1'b1;
          err_d     = load_shift;
          if (!key_ok) key_cnt_d = key_cnt_q + 1'b1;
        end else begin
          data_shift = load_shift;
        end
        if (staenc | stadec) begin
          if ((staenc ^ stadec) && key_ok) begin
            core_start_d = 1'b1;
            mode_d       = stadec ? MODE_DEC : MODE_ENC;
            state_d      = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        err_d = any_cmd;
        if (core_done) begin
          data_load = 1'b1;
`ifdef AES_AUTO_UNLOAD_EN
          state_d   = UNLOAD;
          unl_cnt_d = '0;
`else
          state_d   = IDLE;
`endif
        end
      end
      UNLOAD: begin
`ifdef AES_AUTO_UNLOAD_EN
        err_d      = any_cmd;
        data_shift = 1'b1;
        data_din   = '0;
        unl_cnt_d  = unl_cnt_q + 1'b1;
        if (unl_cnt_q == UCW'(NB - 1)) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      key_cnt_q    <= '0;
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
      mode_q       <= MODE_ENC;
    end else begin
      state_q      <= state_d;
      key_cnt_q    <= key_cnt_d;
      err_q        <= err_d;
      core_start_q <= core_start_d;
      mode_q       <= mode_d;
    end
  end

`ifdef AES_AUTO_UNLOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unl_cnt_q <= '0;
    end else begin
      unl_cnt_q <= unl_cnt_d;
    end
  end
  assign dout_valid = (state_q == UNLOAD);
`else
  assign dout_valid = 1'b0;
`endif

  aes_shift_reg #(.DW(DW)) u_key_reg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (key_shift),
    .din      (din),
    .load_en  (1'b0),
    .load_val ('0),
    .q        (core_key)
  );

  aes_shift_reg #(.DW(DW)) u_data_reg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (data_shift),
    .din      (data_din),
    .load_en  (data_load),
    .load_val (core_dout),
    .q        (core_din)
  );

  assign dout       = core_din[BLK-1 -: DW];
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign core_mode  = mode_q;
  assign core_start = core_start_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl: DW=8 encrypt and DW=32 decrypt instances with a golden core stub.
module tb_aes_stream_ctrl;

  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DW=8 instance
  logic [7:0]   din8 = '0, dout8;
  logic         lk8 = 0, ls8 = 0, se8 = 0, sd8 = 0;
  logic         dv8, busy8, err8, cm8, cs8, cdone8;
  logic [127:0] ck8, cd8, cdo8;
  // DW=32 instance
  logic [31:0]  din32 = '0, dout32;
  logic         lk32 = 0, ls32 = 0, se32 = 0, sd32 = 0;
  logic         dv32, busy32, err32, cm32, cs32, cdone32;
  logic [127:0] ck32, cd32, cdo32;

  aes_stream_ctrl #(.DW(8)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .loadkey(lk8), .load_shift(ls8),
    .staenc(se8), .stadec(sd8), .dout(dout8), .dout_valid(dv8), .busy(busy8),
    .err(err8), .core_key(ck8), .core_din(cd8), .core_mode(cm8),
    .core_start(cs8), .core_dout(cdo8), .core_done(cdone8)
  );

  aes_stream_ctrl #(.DW(32)) dut32 (
    .clk(clk), .rst(rst), .din(din32), .loadkey(lk32), .load_shift(ls32),
    .staenc(se32), .stadec(sd32), .dout(dout32), .dout_valid(dv32), .busy(busy32),
    .err(err32), .core_key(ck32), .core_din(cd32), .core_mode(cm32),
    .core_start(cs32), .core_dout(cdo32), .core_done(cdone32)
  );

  function automatic logic [127:0] golden(input logic mode, input logic [127:0] key, input logic [127:0] txt);
    if (key == K && !mode && txt == PT) return CT;
    if (key == K && mode && txt == CT) return PT;
    return ~txt;
  endfunction

  // Core stub: result sampled at core_start, core_done four cycles later.
  int           m8_cnt = 0, m32_cnt = 0;
  logic [127:0] m8_res = '0, m32_res = '0;
  logic         m8_done = 1'b0, m32_done = 1'b0, fdone8 = 1'b0;
  assign cdone8  = m8_done | fdone8;
  assign cdo8    = m8_res;
  assign cdone32 = m32_done;
  assign cdo32   = m32_res;

  always @(posedge clk) begin
    m8_done <= 1'b0;
    if (cs8) begin
      m8_cnt <= 3;
      m8_res <= golden(cm8, ck8, cd8);
    end else if (m8_cnt > 0) begin
      m8_cnt <= m8_cnt - 1;
      if (m8_cnt == 1) m8_done <= 1'b1;
    end
  end

  always @(posedge clk) begin
    m32_done <= 1'b0;
    if (cs32) begin
      m32_cnt <= 3;
      m32_res <= golden(cm32, ck32, cd32);
    end else if (m32_cnt > 0) begin
      m32_cnt <= m32_cnt - 1;
      if (m32_cnt == 1) m32_done <= 1'b1;
    end
  end

  int dv_hi = 0;
  always @(posedge clk) if (dv8 || dv32) dv_hi <= dv_hi + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst8(input string tag);
    chk({tag, " dout"}, dout8, 0);
    chk({tag, " dout_valid"}, dv8, 0);
    chk({tag, " busy"}, busy8, 0);
    chk({tag, " err"}, err8, 0);
    chk({tag, " core_start"}, cs8, 0);
    chk({tag, " core_mode"}, cm8, 0);
    chk({tag, " core_key"}, ck8, 0);
    chk({tag, " core_din"}, cd8, 0);
  endtask

  task automatic key8(input logic [7:0] b);
    lk8 = 1'b1; din8 = b; tick(); lk8 = 1'b0;
  endtask

  task automatic txt8(input logic [7:0] b);
    ls8 = 1'b1; din8 = b; tick(); ls8 = 1'b0;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp;
  } beat_t;

  beat_t        rd8[16];
  beat_t        rd32[4];
  logic [127:0] ct_v, pt_v, k_v, nt8, nt32, d0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ct_v = CT; pt_v = PT; k_v = K;
    nt8 = '0; nt32 = '0;
    for (int i = 0; i < 16; i++) begin
      rd8[i].exp = {24'h0, ct_v[127-8*i -: 8]};
      rd8[i].din = 32'(8'h30 + i);
      nt8 = {nt8[119:0], rd8[i].din[7:0]};
    end
    for (int i = 0; i < 4; i++) begin
      rd32[i].exp = pt_v[127-32*i -: 32];
      rd32[i].din = 32'hA5A5_0000 + 32'(i);
      nt32 = {nt32[95:0], rd32[i].din};
    end

    // Reset state, then a reset asserted mid-load after a full key.
    repeat (2) tick();
    chk_rst8("reset");
    rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) key8(8'(i));
    ls8 = 1'b1; din8 = 8'hab;
    tick();
    #2 rst = 1'b0;
    #1 chk_rst8("midload reset");
    ls8 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    se8 = 1'b1; tick(); se8 = 1'b0;
    chk("start after reset err", err8, 1);
    chk("start after reset core_start", cs8, 0);
    tick();
    chk("start after reset no start", cs8, 0);
    chk("start after reset busy", busy8, 0);

    // DW=8 FIPS-197 encrypt, with an early start after 15 key beats.
    for (int i = 0; i < 15; i++) key8(8'(i));
    for (int i = 0; i < 16; i++) txt8(8'(i * 17));
    chk("pt core_din", cd8, PT);
    se8 = 1'b1; tick(); se8 = 1'b0;
    chk("early start err", err8, 1);
    chk("early start busy", busy8, 0);
    chk("early start core_start", cs8, 0);
    key8(8'h0f);
    chk("key reg", ck8, K);
    se8 = 1'b1; tick(); se8 = 1'b0;
    chk("enc core_start", cs8, 1);
    chk("enc busy", busy8, 1);
    chk("enc mode", cm8, 0);
    chk("enc core_din", cd8, PT);
    chk("enc err", err8, 0);
    lk8 = 1'b1; din8 = 8'hee; tick(); lk8 = 1'b0;
    chk("run loadkey err", err8, 1);
    chk("run loadkey key kept", ck8, K);
    chk("core_start one cycle", cs8, 0);
    for (int k = 0; k < 20 && busy8 && !dv8; k++) tick();
    chk("enc result loaded", cd8, CT);
`ifdef AES_AUTO_UNLOAD_EN
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("unload8 valid %0d", i), dv8, 1);
      chk($sformatf("unload8 dout %0d", i), dout8, rd8[i].exp);
      chk($sformatf("unload8 busy %0d", i), busy8, 1);
      tick();
    end
    chk("unload8 valid end", dv8, 0);
    chk("unload8 busy end", busy8, 0);
`else
    chk("enc busy clears", busy8, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("readout8 dout %0d", i), dout8, rd8[i].exp);
      ls8 = 1'b1; din8 = rd8[i].din[7:0]; tick(); ls8 = 1'b0;
    end
    chk("readout8 next text", cd8, nt8);
`endif

    // Command conflicts in IDLE.
    d0 = cd8;
    lk8 = 1'b1; ls8 = 1'b1; din8 = 8'h5a; tick(); lk8 = 1'b0; ls8 = 1'b0;
    chk("key+shift err", err8, 1);
    chk("key+shift key", ck8, {k_v[119:0], 8'h5a});
    chk("key+shift data kept", cd8, d0);
    se8 = 1'b1; sd8 = 1'b1; tick(); se8 = 1'b0; sd8 = 1'b0;
    chk("enc+dec err", err8, 1);
    chk("enc+dec core_start", cs8, 0);
    chk("enc+dec busy", busy8, 0);
    tick();
    chk("err pulse width", err8, 0);
    fdone8 = 1'b1; tick(); fdone8 = 1'b0;
    chk("idle core_done data kept", cd8, d0);
    chk("idle core_done busy", busy8, 0);

    // Start together with a load, then reset mid-RUN; the late core_done must be ignored.
    ls8 = 1'b1; se8 = 1'b1; din8 = 8'h77; tick(); ls8 = 1'b0; se8 = 1'b0;
    chk("load+start core_start", cs8, 1);
    chk("load+start core_din", cd8, {d0[119:0], 8'h77});
    #3 rst = 1'b0;
    #1 chk("midrun reset busy", busy8, 0);
    chk("midrun reset core_din", cd8, 0);
    #1 rst = 1'b1;
    repeat (8) tick();
    chk("late done busy", busy8, 0);
    chk("late done core_din", cd8, 0);

    // DW=32 decrypt.
    for (int i = 0; i < 4; i++) begin
      lk32 = 1'b1; din32 = k_v[127-32*i -: 32]; tick(); lk32 = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      ls32 = 1'b1; din32 = ct_v[127-32*i -: 32]; tick(); ls32 = 1'b0;
    end
    chk("dec key reg", ck32, K);
    chk("dec ct reg", cd32, CT);
    sd32 = 1'b1; tick(); sd32 = 1'b0;
    chk("dec core_start", cs32, 1);
    chk("dec mode", cm32, 1);
    chk("dec busy", busy32, 1);
    for (int k = 0; k < 20 && busy32 && !dv32; k++) tick();
    chk("dec result loaded", cd32, PT);
`ifdef AES_AUTO_UNLOAD_EN
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("unload32 valid %0d", i), dv32, 1);
      chk($sformatf("unload32 dout %0d", i), dout32, rd32[i].exp);
      tick();
    end
    chk("unload32 valid end", dv32, 0);
    chk("unload32 busy end", busy32, 0);
`else
    chk("dec busy clears", busy32, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("readout32 dout %0d", i), dout32, rd32[i].exp);
      ls32 = 1'b1; din32 = rd32[i].din; tick(); ls32 = 1'b0;
    end
    chk("readout32 next text", cd32, nt32);
    chk("dout_valid never high", 128'(dv_hi), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
